booth_divider_nr: RTL and testbench

Sequential signed integer divider, the inverse operation to the team's Booth multipliers. It produces one quotient bit per clock using the non-restoring algorithm. A start/busy/done handshake lets a datapath controller issue a divide and collect quotient and remainder. Results are signed two's complement, truncated toward zero: the quotient rounds to zero and the remainder takes the dividend's sign.

---
 rtl/mult_div_pkg.sv | 26 ++
 rtl/booth_divider_nr_addsub.sv | 16 +
 rtl/booth_divider_nr.sv | 136 +++++++++++++
 tb/tb_booth_divider_nr.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the sequential multiply/divide blocks.
// No timing of its own: types, constants and a magnitude helper only.
// No handshake: pure declarations.
package mult_div_pkg;

   localparam int DEF_WIDTH = 16;
   // Widest operand the magnitude helper supports.
   localparam int MAX_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef logic [MAX_WIDTH:0] wide_t;

   // Magnitude of a sign-extended operand. The caller sign-extends its
   // WIDTH-bit value into wide_t and keeps the low WIDTH+1 bits, so
   // |MIN_INT| comes out correctly as 2**(WIDTH-1).
   function automatic wide_t abs_ext(input wide_t x);
      return x[MAX_WIDTH] ? (wide_t'(0) - x) : x;
   endfunction

endpackage

// File: rtl/booth_divider_nr_addsub.sv
// Shared WIDTH+1-bit adder/subtractor for the non-restoring divider.
// Purely combinational, zero latency.
// No handshake: result follows the inputs.
module nr_addsub #(
   parameter int W = 17
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum
);

   // One carry chain: subtract by inverting b and injecting a carry.
   assign sum = a + (b ^ {W{sub}}) + W'(sub);

endmodule

// File: rtl/booth_divider_nr.sv
// Sequential signed divider, non-restoring, one quotient bit per clock.
// Latency: done WIDTH+2 edges after the accepted start; 1 edge for /0 and MIN/-1.
// Backpressure: start is only honoured in IDLE; starts while busy or in DONE are dropped.
module booth_divider_nr
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] dividend,
   input  logic signed [WIDTH-1:0] divisor,
   output logic                    busy,
   output logic                    done,
   output logic [WIDTH-1:0]        quotient,
   output logic [WIDTH-1:0]        remainder,
   output logic                    div_by_zero,
   output logic                    overflow
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   a_reg;     // signed partial remainder
   logic [WIDTH-1:0] q_reg;     // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH:0]   m_reg;     // divisor magnitude, zero-extended
   logic             sq;        // quotient must be negated
   logic             sr;        // remainder must be negated

   wide_t            dvd_wide;
   wide_t            dvs_wide;
   logic [WIDTH:0]   a_shift;
   logic [WIDTH:0]   add_a;
   logic             add_sub;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH-1:0] a_fix;

   assign dvd_wide = {{(MAX_WIDTH+1-WIDTH){dividend[WIDTH-1]}}, dividend};
   assign dvs_wide = {{(MAX_WIDTH+1-WIDTH){divisor[WIDTH-1]}}, divisor};

   assign a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};

   // Steer the single adder: iteration step in CALC, final correction in FIX.
   always_comb begin
      add_a   = a_reg;
      add_sub = 1'b0;
      if (state == CALC) begin
         add_a   = a_shift;
         add_sub = ~a_reg[WIDTH];
      end
   end

   nr_addsub #(.W(WIDTH + 1)) u_addsub (
      .a   (add_a),
      .b   (m_reg),
      .sub (add_sub),
      .sum (add_sum)
   );

   // A negative final partial remainder is restored by adding M back once.
   assign a_fix = a_reg[WIDTH] ? add_sum[WIDTH-1:0] : a_reg[WIDTH-1:0];

   // Control FSM and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         a_reg       <= '0;
         q_reg       <= '0;
         m_reg       <= '0;
         sq          <= 1'b0;
         sr          <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     state       <= DONE;
                  end else if (dividend == MIN_INT && divisor == '1) begin
                     quotient  <= MIN_INT;
                     remainder <= '0;
                     overflow  <= 1'b1;
                     state     <= DONE;
                  end else begin
                     q_reg <= WIDTH'(abs_ext(dvd_wide));
                     m_reg <= (WIDTH+1)'(abs_ext(dvs_wide));
                     a_reg <= '0;
                     sq    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     sr    <= dividend[WIDTH-1];
                     cnt   <= CNT_W'(WIDTH);
                     busy  <= 1'b1;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               a_reg <= add_sum;
               q_reg <= {q_reg[WIDTH-2:0], ~add_sum[WIDTH]};
               cnt   <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               quotient  <= sq ? (WIDTH'(0) - q_reg) : q_reg;
               remainder <= sr ? (WIDTH'(0) - a_fix) : a_fix;
               busy      <= 1'b0;
               state     <= DONE;
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_divider_nr.sv
// Directed and randomized self-checking bench for booth_divider_nr (WIDTH=16).
// Latency is counted in rising edges after the edge that accepted start.
// Inputs change on the falling edge or 1 ns after the rising edge; outputs are sampled 1 ns after.
module tb_booth_divider_nr;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;
   logic        overflow;

   int n_assert;
   int n_fail;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      logic        ov;
      int          lat;
   } vec_t;

   booth_divider_nr #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one divide and wait (bounded) for done; lat = -1 on timeout.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int lat,
                        output logic [15:0] q, output logic [15:0] r,
                        output logic dz, output logic ov);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
      q  = quotient;
      r  = remainder;
      dz = div_by_zero;
      ov = overflow;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      n_assert++;
      if ({busy, done, div_by_zero, overflow} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got busy/done/dz/ov=%b expected 0000",
                  {busy, done, div_by_zero, overflow});
      end
      n_assert++;
      if ({quotient, remainder} !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_results: got q=%h r=%h expected 0/0", quotient, remainder);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_table(input string name, input vec_t v[]);
      int lat;
      logic [15:0] q, r;
      logic dz, ov;
      foreach (v[k]) begin
         do_op(v[k].a, v[k].b, lat, q, r, dz, ov);
         n_assert++;
         if (lat !== v[k].lat) begin
            n_fail++;
            $display("FAIL %s[%0d] latency: got %0d expected %0d", name, k, lat, v[k].lat);
         end
         n_assert++;
         if ({q, r, dz, ov} !== {v[k].q, v[k].r, v[k].dz, v[k].ov}) begin
            n_fail++;
            $display("FAIL %s[%0d] %0d/%0d: got q=%h r=%h dz=%b ov=%b expected q=%h r=%h dz=%b ov=%b",
                     name, k, $signed(v[k].a), $signed(v[k].b), q, r, dz, ov,
                     v[k].q, v[k].r, v[k].dz, v[k].ov);
         end
      end
   endtask

   task automatic test_signs;
      vec_t v[];
      v = new[4];
      v[0] = '{a: 16'd100,    b: 16'd7,    q: 16'd14,    r: 16'd2,    dz: 1'b0, ov: 1'b0, lat: 18};
      v[1] = '{a: -16'sd100,  b: 16'd7,    q: -16'sd14,  r: -16'sd2,  dz: 1'b0, ov: 1'b0, lat: 18};
      v[2] = '{a: 16'd100,    b: -16'sd7,  q: -16'sd14,  r: 16'd2,    dz: 1'b0, ov: 1'b0, lat: 18};
      v[3] = '{a: -16'sd100,  b: -16'sd7,  q: 16'd14,    r: -16'sd2,  dz: 1'b0, ov: 1'b0, lat: 18};
      run_table("signs", v);
   endtask

   task automatic test_special;
      vec_t v[];
      v = new[4];
      v[0] = '{a: 16'd1234,   b: 16'd0,    q: 16'hFFFF,  r: 16'd1234, dz: 1'b1, ov: 1'b0, lat: 1};
      v[1] = '{a: 16'h8000,   b: 16'hFFFF, q: 16'h8000,  r: 16'd0,    dz: 1'b0, ov: 1'b1, lat: 1};
      v[2] = '{a: 16'h8000,   b: 16'd1,    q: 16'h8000,  r: 16'd0,    dz: 1'b0, ov: 1'b0, lat: 18};
      v[3] = '{a: 16'h8000,   b: 16'd0,    q: 16'hFFFF,  r: 16'h8000, dz: 1'b1, ov: 1'b0, lat: 1};
      run_table("special", v);
   endtask

   task automatic test_corners;
      vec_t v[];
      v = new[5];
      v[0] = '{a: 16'h8000,   b: 16'd7,    q: -16'sd4681, r: -16'sd1,  dz: 1'b0, ov: 1'b0, lat: 18};
      v[1] = '{a: 16'd7,      b: 16'h8000, q: 16'd0,      r: 16'd7,    dz: 1'b0, ov: 1'b0, lat: 18};
      v[2] = '{a: 16'h7FFF,   b: 16'h8000, q: 16'd0,      r: 16'h7FFF, dz: 1'b0, ov: 1'b0, lat: 18};
      v[3] = '{a: 16'h8000,   b: 16'h8000, q: 16'd1,      r: 16'd0,    dz: 1'b0, ov: 1'b0, lat: 18};
      v[4] = '{a: 16'd0,      b: 16'd5,    q: 16'd0,      r: 16'd0,    dz: 1'b0, ov: 1'b0, lat: 18};
      run_table("corners", v);
   endtask

   task automatic test_hold;
      int lat;
      logic [15:0] q, r;
      logic dz, ov;
      do_op(16'd1234, 16'd0, lat, q, r, dz, ov);
      repeat (4) @(posedge clk);
      #1;
      n_assert++;
      if ({done, quotient, remainder, div_by_zero} !== {1'b0, 16'hFFFF, 16'd1234, 1'b1}) begin
         n_fail++;
         $display("FAIL hold: got done=%b q=%h r=%h dz=%b expected 0 ffff 04d2 1",
                  done, quotient, remainder, div_by_zero);
      end
   endtask

   task automatic test_back_to_back;
      int ndone;
      int e1;
      int e2;
      bit drop;
      ndone = 0;
      e1 = -1;
      e2 = -1;
      drop = 1'b0;
      @(negedge clk);
      dividend = 16'd30000;
      divisor  = 16'd3;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (drop) begin
            start = 1'b0;
            drop  = 1'b0;
         end
         if (i == 5) begin
            dividend = 16'd9;
            divisor  = 16'd9;
            start    = 1'b1;
            drop     = 1'b1;
         end
         if (done === 1'b1) begin
            ndone++;
            if (ndone == 1) begin
               e1 = i;
               n_assert++;
               if ({quotient, remainder} !== {16'd10000, 16'd0}) begin
                  n_fail++;
                  $display("FAIL b2b_first: got q=%h r=%h expected 2710 0000", quotient, remainder);
               end
               dividend = 16'd30000;
               divisor  = -16'sd3;
               start    = 1'b1;
               drop     = 1'b1;
            end else if (ndone == 2) begin
               e2 = i;
               n_assert++;
               if ({quotient, remainder} !== {-16'sd10000, 16'd0}) begin
                  n_fail++;
                  $display("FAIL b2b_second: got q=%h r=%h expected d8f0 0000", quotient, remainder);
               end
            end
         end
      end
      n_assert++;
      if (ndone !== 2) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d dones expected 2", ndone);
      end
      n_assert++;
      if (e1 !== 18 || e2 !== 37) begin
         n_fail++;
         $display("FAIL b2b_timing: got done edges %0d,%0d expected 18,37", e1, e2);
      end
   endtask

   task automatic test_mid_reset;
      int ndone;
      int lat;
      logic [15:0] q, r;
      logic dz, ov;
      ndone = 0;
      @(negedge clk);
      dividend = 16'd1000;
      divisor  = 16'd3;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_assert++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_busy_before: got %b expected 1", busy);
      end
      rst_n = 1'b0;
      #1;
      n_assert++;
      if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 36'h0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got busy=%b done=%b q=%h r=%h dz=%b ov=%b expected all 0",
                  busy, done, quotient, remainder, div_by_zero, overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) ndone++;
      end
      n_assert++;
      if (ndone !== 0) begin
         n_fail++;
         $display("FAIL midrst_no_done: got %0d active cycles expected 0", ndone);
      end
      do_op(16'd50, 16'd6, lat, q, r, dz, ov);
      n_assert++;
      if ({lat, q, r, dz, ov} !== {32'sd18, 16'd8, 16'd2, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL midrst_after: got lat=%0d q=%h r=%h dz=%b ov=%b expected 18 0008 0002 0 0",
                  lat, q, r, dz, ov);
      end
   endtask

   task automatic test_random;
      int lat;
      logic [15:0] q, r, a, b, qe, re;
      logic dz, ov, dze, ove;
      int sa, sb, le;
      for (int k = 0; k < 150; k++) begin
         a = 16'($urandom);
         b = (k % 4 == 0) ? 16'($urandom_range(0, 4)) - 16'd2 : 16'($urandom);
         if (k % 10 == 0) a = 16'h8000;
         sa = int'($signed(a));
         sb = int'($signed(b));
         dze = 1'b0;
         ove = 1'b0;
         le  = 18;
         if (sb == 0) begin
            qe = 16'hFFFF;
            re = a;
            dze = 1'b1;
            le = 1;
         end else if (sa == -32768 && sb == -1) begin
            qe = 16'h8000;
            re = 16'd0;
            ove = 1'b1;
            le = 1;
         end else begin
            qe = 16'(sa / sb);
            re = 16'(sa % sb);
         end
         do_op(a, b, lat, q, r, dz, ov);
         n_assert++;
         if ({lat, q, r, dz, ov} !== {le, qe, re, dze, ove}) begin
            n_fail++;
            $display("FAIL random[%0d] %0d/%0d: got lat=%0d q=%h r=%h dz=%b ov=%b expected lat=%0d q=%h r=%h dz=%b ov=%b",
                     k, sa, sb, lat, q, r, dz, ov, le, qe, re, dze, ove);
         end
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      test_reset();
      test_signs();
      test_special();
      test_corners();
      test_hold();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
